// File: rtl/amo_pkg.sv
// Shared definitions for the AMO read-modify-write sequencer and its ALU.
// LR/SC encodings are only legal when the design is built with AMO_LRSC_EN.
package amo_pkg;

  localparam int unsigned AMO_ADDR_W = 32;
  localparam int unsigned AMO_DATA_W = 32;

  localparam logic [2:0] AMO_ADD  = 3'b000;
  localparam logic [2:0] AMO_SWAP = 3'b001;
  localparam logic [2:0] AMO_AND  = 3'b010;
  localparam logic [2:0] AMO_OR   = 3'b011;
  localparam logic [2:0] AMO_LR   = 3'b100;
  localparam logic [2:0] AMO_SC   = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RSP
  } amo_state_e;

  // Word AMOs are always legal; LR/SC only when the reservation logic exists.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic lrsc_en);
    return (f3[2] == 1'b0) || (lrsc_en && ((f3 == AMO_LR) || (f3 == AMO_SC)));
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO update: new memory value from (funct3, old value, rs2).
// SWAP and SC both store the operand unchanged.
module amo_alu
  import amo_pkg::*;
#(
  parameter int unsigned W = AMO_DATA_W
) (
  input  logic [2:0]   i_funct3,
  input  logic [W-1:0] i_old,
  input  logic [W-1:0] i_operand,
  output logic [W-1:0] o_new_c
);

  always_comb begin
    o_new_c = i_operand;
    case (i_funct3)
      AMO_ADD: o_new_c = i_old + i_operand;
      AMO_AND: o_new_c = i_old & i_operand;
      AMO_OR:  o_new_c = i_old | i_operand;
      default: o_new_c = i_operand;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// Sequenced read-modify-write engine for RISC-V AMOs with aq/rl ordering.
// Build option AMO_LRSC_EN adds LR/SC support with a single reservation.
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int unsigned ADDR_W = AMO_ADDR_W,
  parameter int unsigned DATA_W = AMO_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic              i_req_aq,
  input  logic              i_req_rl,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_order_hold,
  output logic              o_drain_req,
  input  logic              i_drain_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

`ifdef AMO_LRSC_EN
  localparam logic LRSC_EN = 1'b1;
`else
  localparam logic LRSC_EN = 1'b0;
`endif

  amo_state_e        r_state;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_aligned;
  logic              w_legal;
  logic [DATA_W-1:0] w_new;

  assign w_aligned = (i_req_addr[1:0] == 2'b00);
  assign w_legal   = funct3_legal(i_req_funct3, LRSC_EN);

`ifdef AMO_LRSC_EN
  logic              r_resv_valid;
  logic [ADDR_W-1:0] r_resv_addr;
  logic              w_sc_hit;

  assign w_sc_hit = r_resv_valid && (r_resv_addr == i_req_addr);
`endif

  // New value is formed straight from the returning read data.
  amo_alu #(
    .W(DATA_W)
  ) u_alu (
    .i_funct3 (r_funct3),
    .i_old    (i_mem_rdata),
    .i_operand(r_data),
    .o_new_c  (w_new)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      o_req_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_err    <= 1'b0;
      o_rsp_data   <= '0;
      o_order_hold <= 1'b0;
      o_drain_req  <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
`ifdef AMO_LRSC_EN
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_funct3     <= i_req_funct3;
          r_addr       <= i_req_addr;
          r_data       <= i_req_data;
          o_req_ready  <= 1'b0;
          o_order_hold <= i_req_aq;
`ifdef AMO_LRSC_EN
          if (i_req_funct3 == AMO_SC) r_resv_valid <= 1'b0;
`endif
          if (!w_aligned || !w_legal) begin
            r_state     <= RSP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_data  <= '0;
          end
`ifdef AMO_LRSC_EN
          else if ((i_req_funct3 == AMO_SC) && !w_sc_hit) begin
            r_state     <= RSP;
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= DATA_W'(1);
          end
`endif
          else if (i_req_rl) begin
            r_state     <= DRAIN;
            o_drain_req <= 1'b1;
          end
`ifdef AMO_LRSC_EN
          else if (i_req_funct3 == AMO_SC) begin
            r_state     <= WR_REQ;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= i_req_addr;
            o_mem_wdata <= i_req_data;
            o_rsp_data  <= '0;
          end
`endif
          else begin
            r_state    <= RD_REQ;
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= i_req_addr;
          end
        end

        DRAIN: if (i_drain_done) begin
          o_drain_req <= 1'b0;
          o_mem_req   <= 1'b1;
          o_mem_addr  <= r_addr;
`ifdef AMO_LRSC_EN
          if (r_funct3 == AMO_SC) begin
            r_state     <= WR_REQ;
            o_mem_we    <= 1'b1;
            o_mem_wdata <= r_data;
            o_rsp_data  <= '0;
          end else begin
`else
          begin
`endif
            r_state  <= RD_REQ;
            o_mem_we <= 1'b0;
          end
        end

        RD_REQ: if (i_mem_gnt) begin
          r_state   <= RD_WAIT;
          o_mem_req <= 1'b0;
        end

        // Read data is only trusted once the read has been granted.
        RD_WAIT: if (i_mem_rvalid) begin
          o_rsp_data <= i_mem_rdata;
`ifdef AMO_LRSC_EN
          if (r_funct3 == AMO_LR) begin
            r_state      <= RSP;
            o_rsp_valid  <= 1'b1;
            r_resv_valid <= 1'b1;
            r_resv_addr  <= r_addr;
          end else begin
            if (r_addr == r_resv_addr) r_resv_valid <= 1'b0;
`else
          begin
`endif
            r_state     <= WR_REQ;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_wdata <= w_new;
          end
        end

        WR_REQ: if (i_mem_gnt) begin
          r_state     <= RSP;
          o_mem_req   <= 1'b0;
          o_mem_we    <= 1'b0;
          o_rsp_valid <= 1'b1;
        end

        RSP: if (i_rsp_ready) begin
          r_state      <= IDLE;
          o_rsp_valid  <= 1'b0;
          o_rsp_err    <= 1'b0;
          o_order_hold <= 1'b0;
          o_req_ready  <= 1'b1;
        end

        default: begin
          r_state      <= IDLE;
          o_req_ready  <= 1'b1;
          o_rsp_valid  <= 1'b0;
          o_rsp_err    <= 1'b0;
          o_order_hold <= 1'b0;
          o_drain_req  <= 1'b0;
          o_mem_req    <= 1'b0;
          o_mem_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer: directed scenarios plus randomized
// AMO traffic against a word-array memory model and a reservation model.
module tb_amo_sequencer;

  localparam logic [2:0] F_ADD  = 3'd0;
  localparam logic [2:0] F_SWAP = 3'd1;
  localparam logic [2:0] F_AND  = 3'd2;
  localparam logic [2:0] F_OR   = 3'd3;
  localparam logic [2:0] F_LR   = 3'd4;
  localparam logic [2:0] F_SC   = 3'd5;

`ifdef AMO_LRSC_EN
  localparam bit LRSC = 1'b1;
`else
  localparam bit LRSC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_data;
  logic        i_req_aq;
  logic        i_req_rl;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_order_hold;
  logic        o_drain_req;
  logic        i_drain_done;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  always #5 clk = ~clk;

  amo_sequencer dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_funct3(i_req_funct3),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .i_req_aq    (i_req_aq),
    .i_req_rl    (i_req_rl),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_order_hold(o_order_hold),
    .o_drain_req (o_drain_req),
    .i_drain_done(i_drain_done),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_gnt   (i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata (i_mem_rdata)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Memory seen by the DUT, and the bench's independent expectation of it.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int          gnt_max   = 0;
  int          rd_min    = 0;
  int          rd_max    = 0;
  bit          inject_en = 1'b0;
  int          n_rd      = 0;
  int          n_wr      = 0;
  bit          rd_pending = 1'b0;
  int          rd_delay  = 0;
  logic [31:0] rd_data   = '0;
  bit          armed     = 1'b0;
  int          gnt_wait  = 0;

  bit          resv_valid = 1'b0;
  logic [31:0] resv_addr  = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit f3_legal(input logic [2:0] f3);
    return (f3 <= 3'd3) || (LRSC && ((f3 == F_LR) || (f3 == F_SC)));
  endfunction

  function automatic logic [31:0] amo_apply(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [31:0] opd);
    logic [32:0] sum;
    sum = {1'b0, old} + {1'b0, opd};
    case (f3)
      F_ADD:   return sum[31:0];
      F_AND:   return old & opd;
      F_OR:    return old | opd;
      default: return opd;
    endcase
  endfunction

  // Memory responder: random grant latency, random read latency, optional
  // stray rvalid pulses while a read is still waiting for its grant.
  initial begin
    bit granted;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    forever begin
      @(negedge clk);
      granted      = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom;
      if (rd_pending) begin
        if (rd_delay == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = rd_data;
          rd_pending   = 1'b0;
        end else begin
          rd_delay--;
        end
      end
      if (o_mem_req) begin
        if (!armed) begin
          armed    = 1'b1;
          gnt_wait = $urandom_range(0, gnt_max);
        end
        if (gnt_wait == 0) begin
          armed     = 1'b0;
          granted   = 1'b1;
          i_mem_gnt = 1'b1;
          if (o_mem_we) begin
            mem[o_mem_addr[7:2]] = o_mem_wdata;
            n_wr++;
          end else begin
            rd_pending = 1'b1;
            rd_delay   = $urandom_range(rd_min, rd_max);
            rd_data    = mem[o_mem_addr[7:2]];
            n_rd++;
          end
        end else begin
          gnt_wait--;
        end
      end
      if (inject_en && o_mem_req && !o_mem_we && !granted && !i_mem_rvalid &&
          ($urandom_range(0, 3) == 0)) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = $urandom;
      end
    end
  end

  // One AMO from accept to response handshake; exp_lat < 0 skips the latency check.
  task automatic run_amo(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         input bit aq, input bit rl, input int drain_dly, input int stall,
                         input int exp_lat);
    logic [31:0] exp_rsp;
    logic [31:0] held;
    bit          exp_err;
    bit          sc_hit;
    bit          sc_fail;
    int          idx, exp_rd, exp_wr, exp_drain;
    int          rd0, wr0, k, first_rsp, drain_cnt, bad_ready, bad_hold, bad_overlap, bad_stall;

    idx       = int'(addr[7:2]);
    exp_err   = (addr[1:0] != 2'b00) || !f3_legal(f3);
    exp_rsp   = '0;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_drain = 0;
    sc_hit    = 1'b0;
    sc_fail   = 1'b0;
    if (LRSC && (f3 == F_SC)) begin
      sc_hit     = resv_valid && (resv_addr == addr);
      resv_valid = 1'b0;
    end
    if (!exp_err) begin
      if (f3 == F_LR) begin
        exp_rsp    = ref_mem[idx];
        exp_rd     = 1;
        resv_valid = 1'b1;
        resv_addr  = addr;
      end else if (f3 == F_SC) begin
        if (sc_hit) begin
          ref_mem[idx] = data;
          exp_wr       = 1;
        end else begin
          exp_rsp = 32'd1;
          sc_fail = 1'b1;
        end
      end else begin
        exp_rsp      = ref_mem[idx];
        ref_mem[idx] = amo_apply(f3, ref_mem[idx], data);
        exp_rd       = 1;
        exp_wr       = 1;
        if (resv_valid && (resv_addr == addr)) resv_valid = 1'b0;
      end
      if (rl && !sc_fail) exp_drain = drain_dly + 1;
    end

    check_val("req_ready_idle", 64'(o_req_ready), 64'd1);
    rd0          = n_rd;
    wr0          = n_wr;
    i_req_valid  = 1'b1;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_data   = data;
    i_req_aq     = aq;
    i_req_rl     = rl;
    i_drain_done = 1'b0;
    i_rsp_ready  = 1'b0;

    k = 0; first_rsp = -1; drain_cnt = 0;
    bad_ready = 0; bad_hold = 0; bad_overlap = 0; bad_stall = 0;
    while ((first_rsp < 0) && (k < 300)) begin
      @(negedge clk);
      k++;
      i_req_valid = 1'b0;
      if (o_drain_req) drain_cnt++;
      if (o_drain_req && o_mem_req) bad_overlap++;
      if (o_req_ready) bad_ready++;
      if (o_order_hold !== aq) bad_hold++;
      if (o_rsp_valid) first_rsp = k;
      i_drain_done = (k > drain_dly);
    end
    check_val("rsp_timeout", 64'(first_rsp < 0), 64'd0);
    if (exp_lat >= 0) check_val("rsp_latency", 64'(first_rsp), 64'(exp_lat));
    check_val("rsp_data", 64'(o_rsp_data), 64'(exp_rsp));
    check_val("rsp_err", 64'(o_rsp_err), 64'(exp_err));

    held = o_rsp_data;
    repeat (stall) begin
      @(negedge clk);
      if (!o_rsp_valid || (o_rsp_data !== held) || o_req_ready) bad_stall++;
      if (o_order_hold !== aq) bad_hold++;
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready  = 1'b0;
    i_drain_done = 1'b0;

    check_val("post_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check_val("post_req_ready", 64'(o_req_ready), 64'd1);
    check_val("post_order_hold", 64'(o_order_hold), 64'd0);
    check_val("rsp_stable", 64'(bad_stall), 64'd0);
    check_val("busy_req_ready", 64'(bad_ready), 64'd0);
    check_val("order_hold", 64'(bad_hold), 64'd0);
    check_val("drain_cycles", 64'(drain_cnt), 64'(exp_drain));
    check_val("mem_during_drain", 64'(bad_overlap), 64'd0);
    check_val("mem_reads", 64'(n_rd - rd0), 64'(exp_rd));
    check_val("mem_writes", 64'(n_wr - wr0), 64'(exp_wr));
    check_val("mem_word", 64'(mem[idx]), 64'(ref_mem[idx]));
  endtask

  initial begin
    int bad;
    int wr0;
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          rl;
    int          r;

    i_rst        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_funct3 = '0;
    i_req_addr   = '0;
    i_req_data   = '0;
    i_req_aq     = 1'b0;
    i_req_rl     = 1'b0;
    i_rsp_ready  = 1'b0;
    i_drain_done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    repeat (2) @(negedge clk);
    check_val("rst_req_ready", 64'(o_req_ready), 64'd1);
    check_val("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check_val("rst_rsp_err", 64'(o_rsp_err), 64'd0);
    check_val("rst_rsp_data", 64'(o_rsp_data), 64'd0);
    check_val("rst_mem_req", 64'(o_mem_req), 64'd0);
    check_val("rst_mem_we", 64'(o_mem_we), 64'd0);
    check_val("rst_drain_req", 64'(o_drain_req), 64'd0);
    check_val("rst_order_hold", 64'(o_order_hold), 64'd0);
    check_val("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check_val("rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // Zero-wait memory: ADD then a SWAP/AND/OR chain on 0x10.
    mem[4] = 32'h0; ref_mem[4] = 32'h0;
    run_amo(F_ADD,  32'h10, 32'h5,  1'b0, 1'b0, 0, 0, 4);
    check_val("add_mem", 64'(mem[4]), 64'h5);
    run_amo(F_SWAP, 32'h10, 32'hFF, 1'b0, 1'b0, 0, 0, 4);
    run_amo(F_AND,  32'h10, 32'h0F, 1'b0, 1'b0, 0, 0, 4);
    run_amo(F_OR,   32'h10, 32'hF0, 1'b0, 1'b0, 0, 0, 4);
    check_val("chain_mem", 64'(mem[4]), 64'hFF);

    // Release with a slow drain, acquire held through the handshake.
    run_amo(F_ADD, 32'h10, 32'h1, 1'b1, 1'b1, 3, 0, 8);
    run_amo(F_OR,  32'h14, 32'h3, 1'b0, 1'b1, 0, 0, 5);

    // Misaligned address and illegal funct3.
    run_amo(F_ADD,  32'h12, 32'h3, 1'b0, 1'b0, 0, 0, 1);
    run_amo(3'b110, 32'h10, 32'h3, 1'b1, 1'b0, 0, 2, 1);

    // Wraparound ADD with a stalled response.
    mem[16] = 32'hFFFF_FFFF; ref_mem[16] = 32'hFFFF_FFFF;
    run_amo(F_ADD, 32'h40, 32'h2, 1'b0, 1'b0, 0, 5, 4);
    check_val("wrap_mem", 64'(mem[16]), 64'h1);

    // Reset while waiting for read data; the late rvalid must be ignored.
    rd_min = 3; rd_max = 3;
    wr0 = n_wr;
    i_req_valid  = 1'b1;
    i_req_funct3 = F_ADD;
    i_req_addr   = 32'h40;
    i_req_data   = 32'h7;
    i_req_aq     = 1'b1;
    i_req_rl     = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b0;
    check_val("rst_t_rd_req", 64'(o_mem_req), 64'd1);
    @(negedge clk);
    check_val("rst_t_rd_wait", 64'(o_mem_req), 64'd0);
    check_val("rst_t_hold", 64'(o_order_hold), 64'd1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_val("rst_t_req_ready", 64'(o_req_ready), 64'd1);
    check_val("rst_t_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check_val("rst_t_hold_clr", 64'(o_order_hold), 64'd0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid || o_mem_req || !o_req_ready) bad++;
    end
    check_val("rst_t_late_rvalid", 64'(bad), 64'd0);
    check_val("rst_t_no_write", 64'(n_wr - wr0), 64'd0);
    check_val("rst_t_mem", 64'(mem[16]), 64'(ref_mem[16]));
    resv_valid = 1'b0;
    rd_min = 0; rd_max = 0;

`ifdef AMO_LRSC_EN
    run_amo(F_LR, 32'h20, 32'h0,        1'b0, 1'b0, 0, 0, 3);
    run_amo(F_SC, 32'h20, 32'hABCD_0123, 1'b0, 1'b0, 0, 0, 2);
    check_val("sc_ok_mem", 64'(mem[8]), 64'hABCD_0123);
    run_amo(F_SC, 32'h20, 32'h5555_0000, 1'b0, 1'b0, 0, 0, 1);
    check_val("sc_fail_mem", 64'(mem[8]), 64'hABCD_0123);
`endif

    // Randomized traffic over a small address window.
    gnt_max = 2; rd_min = 0; rd_max = 3; inject_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 11);
      if (r < 8)       f3 = 3'(r % 4);
      else if (r < 10) f3 = (r == 8) ? F_LR : F_SC;
      else             f3 = 3'($urandom_range(4, 7));
      addr = 32'h80 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
      rl = 1'($urandom_range(0, 1));
      if (f3 == F_SC) rl = 1'b0;
      run_amo(f3, addr, $urandom, 1'($urandom_range(0, 1)), rl,
              $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
